// File: rtl/rpspmc_fir_pkg.sv
// -----------------------------------------------------------------------------
// rpspmc_fir_pkg
// Shared definitions for the time-multiplexed boxcar FIR/decimation engine
// scheduler: default geometry, the scheduler state encoding and the helper
// that bounds the requested window length to the engine depth.
// -----------------------------------------------------------------------------
package rpspmc_fir_pkg;

  localparam int NCH_DEF        = 4;   // channels sharing the engine
  localparam int NCH_L_DEF      = 2;   // channel index width
  localparam int FIR_DECI_L_DEF = 6;   // log2 of the engine depth
  localparam int DIV_W_DEF      = 16;  // sample-period divider width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_TICK,
    ST_SERVE
  } state_e;

  // Requested window lengths beyond the engine depth run at full depth.
  function automatic logic [3:0] clamp_len_l(input logic [3:0]  len_l,
                                             input int unsigned max_l);
    if (32'(len_l) > max_l) return 4'(max_l);
    return len_l;
  endfunction

endpackage

// File: rtl/fir_tick_div.sv
// -----------------------------------------------------------------------------
// fir_tick_div
// Loadable down-counter that produces the per-sample timebase. While running
// it counts down; the cycle it reaches zero raises tick and reloads from div,
// so the tick period is div+1 clocks (div=0 ticks every clock).
//
// Ports:
//   a_clk, a_resetn : clock, synchronous active-low reset
//   load            : force a reload from div (takes priority)
//   run             : count enable; tick is only raised while running
//   div             : sample period in clocks minus one, sampled at reload
//   tick            : one-cycle sample strobe (combinational from count)
// -----------------------------------------------------------------------------
module fir_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             a_clk,
  input  logic             a_resetn,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = run && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      cnt_q <= '0;
    end else if (load || tick) begin
      cnt_q <= div;
    end else if (run) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/axis_fir_deci_sched.sv
// -----------------------------------------------------------------------------
// axis_fir_deci_sched
// Scheduler for one shared boxcar FIR/decimation engine serving NCH channels.
// On every sample tick it walks the channels round-robin, one per clock,
// issuing a step strobe for active channels and a clear strobe for inactive
// ones, tracks per-channel window fill and flags engine results (engine
// latency 1). All outputs are registered and line up with the state they
// describe (busy is high in exactly the cycles the strobes may be).
//
// Ports:
//   a_clk, a_resetn : clock, synchronous active-low reset
//   cfg_enable      : run enable; low returns to IDLE on the next clock
//   cfg_div         : sample period in clocks minus one
//   cfg_len_l       : log2 window length (clamped to FIR_DECI_L)
//   ch_active       : per-channel upstream tvalid
//   fir_sel         : channel addressed by the engine this cycle
//   fir_step        : engine ingests a sample for fir_sel
//   fir_clear       : engine zeroes the state of fir_sel
//   ch_filled       : per-channel window fully populated
//   out_tvalid      : engine result valid (pulse), channel on out_tid
//   busy            : scheduler in FLUSH or SERVE
//   overrun         : sticky, a tick arrived while still serving
// -----------------------------------------------------------------------------
module axis_fir_deci_sched
  import rpspmc_fir_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int NCH_L      = NCH_L_DEF,
  parameter int FIR_DECI_L = FIR_DECI_L_DEF,
  parameter int DIV_W      = DIV_W_DEF
) (
  input  logic             a_clk,
  input  logic             a_resetn,
  input  logic             cfg_enable,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [3:0]       cfg_len_l,
  input  logic [NCH-1:0]   ch_active,
  output logic [NCH_L-1:0] fir_sel,
  output logic             fir_step,
  output logic             fir_clear,
  output logic [NCH-1:0]   ch_filled,
  output logic             out_tvalid,
  output logic [NCH_L-1:0] out_tid,
  output logic             busy,
  output logic             overrun
);

  localparam int               FILL_W  = FIR_DECI_L + 1;
  localparam logic [NCH_L-1:0] LAST_CH = NCH_L'(NCH - 1);

  state_e             state_q, state_d;
  logic [NCH_L-1:0]   k_q, k_d;
  logic [3:0]         len_l_q, len_l_d, len_l_cfg;
  logic [FILL_W-1:0]  fill_q [NCH];
  logic [FILL_W-1:0]  fill_d [NCH];
  logic [FILL_W-1:0]  lim, fill_inc;

  logic [NCH_L-1:0]   sel_d, tid_d;
  logic               step_d, clear_d, tvalid_d, busy_d, overrun_d;
  logic [NCH-1:0]     filled_d;

  logic               tick, div_run, div_load;

  assign len_l_cfg = clamp_len_l(cfg_len_l, FIR_DECI_L);
  assign lim       = FILL_W'(1) << len_l_q;

  // The divider is reloaded when FLUSH hands over to WAIT_TICK so the first
  // sample burst lands a full period after the engine was cleared.
  assign div_run  = (state_q == ST_WAIT_TICK) || (state_q == ST_SERVE);
  assign div_load = (state_q == ST_FLUSH) && (state_d == ST_WAIT_TICK);

  fir_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .a_clk    (a_clk),
    .a_resetn (a_resetn),
    .load     (div_load),
    .run      (div_run),
    .div      (cfg_div),
    .tick     (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    len_l_d   = len_l_q;
    fill_d    = fill_q;
    filled_d  = ch_filled;
    overrun_d = overrun;
    sel_d     = '0;
    step_d    = 1'b0;
    clear_d   = 1'b0;
    fill_inc  = '0;
    // Engine result follows its step by one clock.
    tvalid_d  = fir_step & ch_filled[fir_sel];
    tid_d     = fir_sel;

    case (state_q)
      ST_IDLE: begin
        len_l_d   = len_l_cfg;
        overrun_d = 1'b0;
        state_d   = ST_FLUSH;
        k_d       = '0;
      end
      ST_FLUSH: begin
        if (k_q == LAST_CH) state_d = ST_WAIT_TICK;
        else                k_d     = k_q + 1'b1;
      end
      ST_WAIT_TICK: begin
        // A new window length invalidates every channel's history.
        if (len_l_cfg != len_l_q) begin
          len_l_d = len_l_cfg;
          state_d = ST_FLUSH;
          k_d     = '0;
        end else if (tick) begin
          state_d = ST_SERVE;
          k_d     = '0;
        end
      end
      ST_SERVE: begin
        if (tick) overrun_d = 1'b1;  // tick dropped, burst completes
        if (k_q == LAST_CH) state_d = ST_WAIT_TICK;
        else                k_d     = k_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!cfg_enable) begin
      state_d  = ST_IDLE;
      k_d      = '0;
      tvalid_d = 1'b0;
      tid_d    = '0;
    end

    // Strobes and fill bookkeeping belong to the cycle being entered.
    case (state_d)
      ST_IDLE, ST_FLUSH: begin
        fill_d   = '{default: '0};
        filled_d = '0;
        if (state_d == ST_FLUSH) begin
          clear_d = 1'b1;
          sel_d   = k_d;
        end
      end
      ST_SERVE: begin
        sel_d = k_d;
        if (ch_active[k_d]) begin
          fill_inc     = (fill_q[k_d] >= lim) ? lim : fill_q[k_d] + 1'b1;
          step_d       = 1'b1;
          fill_d[k_d]  = fill_inc;
          filled_d[k_d] = (fill_inc == lim);
        end else begin
          clear_d       = 1'b1;
          fill_d[k_d]   = '0;
          filled_d[k_d] = 1'b0;
        end
      end
      default: ;
    endcase

    busy_d = (state_d == ST_FLUSH) || (state_d == ST_SERVE);
  end

  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      len_l_q    <= '0;
      // NOTE: the fill counters are a small register array, not RAM, so they
      // are reset with the rest of the state.
      fill_q     <= '{default: '0};
      fir_sel    <= '0;
      fir_step   <= 1'b0;
      fir_clear  <= 1'b0;
      ch_filled  <= '0;
      out_tvalid <= 1'b0;
      out_tid    <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_l_q    <= len_l_d;
      fill_q     <= fill_d;
      fir_sel    <= sel_d;
      fir_step   <= step_d;
      fir_clear  <= clear_d;
      ch_filled  <= filled_d;
      out_tvalid <= tvalid_d;
      out_tid    <= tid_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_axis_fir_deci_sched.sv
// -----------------------------------------------------------------------------
// tb_axis_fir_deci_sched
// Self-checking bench for the FIR engine scheduler. A burst-level model of
// the per-channel window fill predicts strobes and ch_filled in each serve
// slot and pushes expected engine results (channel, cycle) into a scoreboard
// that a negedge monitor pops whenever out_tvalid is seen or is due.
// -----------------------------------------------------------------------------
module tb_axis_fir_deci_sched;

  localparam int NCH = 4;

  logic        a_clk = 1'b0;
  logic        a_resetn;
  logic        cfg_enable;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_len_l;
  logic [3:0]  ch_active;
  logic [1:0]  fir_sel;
  logic        fir_step;
  logic        fir_clear;
  logic [3:0]  ch_filled;
  logic        out_tvalid;
  logic [1:0]  out_tid;
  logic        busy;
  logic        overrun;

  axis_fir_deci_sched dut (
    .a_clk      (a_clk),
    .a_resetn   (a_resetn),
    .cfg_enable (cfg_enable),
    .cfg_div    (cfg_div),
    .cfg_len_l  (cfg_len_l),
    .ch_active  (ch_active),
    .fir_sel    (fir_sel),
    .fir_step   (fir_step),
    .fir_clear  (fir_clear),
    .ch_filled  (ch_filled),
    .out_tvalid (out_tvalid),
    .out_tid    (out_tid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 a_clk = ~a_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge a_clk) cyc <= cyc + 1;

  typedef struct {
    int tid;
    int cyc;
  } exp_t;

  exp_t           sb[$];
  int             fill_m [NCH];
  logic [NCH-1:0] filled_m;
  int             len_m;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every result must match the next expected entry in
  // channel and cycle; an entry that comes due without a pulse is missing.
  always @(negedge a_clk) begin
    exp_t e;
    if (out_tvalid) begin
      if (sb.size() == 0) begin
        check("tv_unexpected", out_tvalid, 0);
      end else begin
        e = sb.pop_front();
        check("tv_tid", out_tid, e.tid);
        check("tv_cycle", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("tv_missing", out_tvalid, 1);
    end
  end

  task automatic step();
    @(posedge a_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) fill_m[i] = 0;
    filled_m = '0;
  endtask

  task automatic check_zero_outputs();
    check("rst_sel", fir_sel, 0);
    check("rst_step", fir_step, 0);
    check("rst_clear", fir_clear, 0);
    check("rst_filled", ch_filled, 0);
    check("rst_tvalid", out_tvalid, 0);
    check("rst_tid", out_tid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
  endtask

  task automatic flush_seq();
    for (int k = 0; k < NCH; k++) begin
      step();
      check("flush_clear", fir_clear, 1);
      check("flush_step", fir_step, 0);
      check("flush_sel", fir_sel, k);
      check("flush_busy", busy, 1);
      check("flush_filled", ch_filled, 0);
      check("flush_overrun", overrun, 0);
    end
    model_reset();
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      step();
      check("gap_step", fir_step, 0);
      check("gap_clear", fir_clear, 0);
      check("gap_busy", busy, 0);
    end
  endtask

  task automatic burst();
    int lim;
    lim = 1 << len_m;
    for (int k = 0; k < NCH; k++) begin
      step();
      if (ch_active[k]) begin
        fill_m[k] = (fill_m[k] >= lim) ? lim : fill_m[k] + 1;
        filled_m[k] = (fill_m[k] == lim);
        if (fill_m[k] == lim) sb.push_back('{tid: k, cyc: cyc + 1});
      end else begin
        fill_m[k]   = 0;
        filled_m[k] = 1'b0;
      end
      check("srv_sel", fir_sel, k);
      check("srv_step", fir_step, ch_active[k]);
      check("srv_clear", fir_clear, !ch_active[k]);
      check("srv_busy", busy, 1);
      check("srv_filled", ch_filled, filled_m);
    end
  endtask

  task automatic run_bursts(input int n, input int g);
    repeat (n) begin
      burst();
      gap(g);
    end
  endtask

  initial begin
    a_resetn   = 1'b0;
    cfg_enable = 1'b0;
    cfg_div    = 16'd9;
    cfg_len_l  = 4'd2;
    ch_active  = 4'b1111;
    len_m      = 2;
    model_reset();

    // Reset state.
    repeat (3) step();
    check_zero_outputs();
    a_resetn = 1'b1;
    step();
    check("idle_busy", busy, 0);
    check("idle_clear", fir_clear, 0);

    // Enable: flush all channels, first burst a full period later, then
    // bursts every 10 clocks; window of 4 fills on the 4th burst.
    cfg_enable = 1'b1;
    flush_seq();
    gap(10);
    run_bursts(6, 6);

    // Channel 2 idle for one burst: cleared, then needs 4 new samples.
    ch_active = 4'b1011;
    burst();
    ch_active = 4'b1111;
    gap(6);
    run_bursts(5, 6);

    // Window length change while running: flush, window of 8.
    cfg_len_l = 4'd3;
    flush_seq();
    len_m = 3;
    gap(10);
    run_bursts(9, 6);

    // Oversized request clamps to the full engine depth of 64.
    cfg_len_l = 4'd9;
    flush_seq();
    len_m = 6;
    gap(10);
    run_bursts(65, 6);

    // Overrun: period of 2 clocks is shorter than a 4-slot burst.
    cfg_enable = 1'b0;
    cfg_div    = 16'd1;
    cfg_len_l  = 4'd2;
    step();
    check("dis_busy", busy, 0);
    check("dis_filled", ch_filled, 0);
    check("dis_overrun", overrun, 0);
    cfg_enable = 1'b1;
    flush_seq();
    len_m = 2;
    gap(2);
    burst();
    step();
    check("ovr_set", overrun, 1);
    check("ovr_busy", busy, 0);
    gap(1);
    burst();
    gap(2);
    burst();
    step();
    check("ovr_sticky", overrun, 1);

    // Disable and re-enable clears overrun; back to a 10-clock period.
    cfg_enable = 1'b0;
    step();
    check("dis2_busy", busy, 0);
    cfg_div    = 16'd9;
    cfg_enable = 1'b1;
    flush_seq();
    gap(10);
    burst();
    gap(6);

    // Reset during serve slot 1: reset state next clock, no trailing result.
    step();
    check("pre_rst_sel0", fir_sel, 0);
    step();
    check("pre_rst_sel1", fir_sel, 1);
    a_resetn = 1'b0;
    step();
    check_zero_outputs();
    a_resetn = 1'b1;
    flush_seq();
    gap(10);
    burst();
    gap(6);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
